// File: rtl/aud_dac_serializer_if.sv
// Stereo PCM frame push channel (valid/ready) into aud_dac_serializer.
interface aud_dac_serializer_if #(
    parameter int unsigned SAMPLE_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/aud_dac_serializer.sv
// Stereo audio DAC serializer: frame FIFO plus codec-slave BCLK/LRCK/DACDAT generation (I2S or left-justified).
// Optional build macro AUD_DAC_UNDERRUN_CNT_EN adds a saturating underrun counter on underrun_cnt.
module aud_dac_serializer #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned BCLK_DIV   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned I2S_MODE   = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    aud_dac_serializer_if.slave in_bus,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);
    localparam int unsigned FRAME_BITS = 2 * SLOT_W;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W      = AW + 1;
    localparam int unsigned SIDX_W     = $clog2(SAMPLE_W);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_BITS   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] OFFSET      = BIT_W'(I2S_MODE);
    localparam logic [BIT_W-1:0] SAMPLE_BITS = BIT_W'(SAMPLE_W);
    localparam logic [BIT_W-1:0] SAMPLE_MSB  = BIT_W'(SAMPLE_W - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [SAMPLE_W-1:0] left_hold;
    logic [SAMPLE_W-1:0] right_hold;
    logic [SAMPLE_W-1:0] fifo_left  [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] fifo_right [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    logic                tick;
    logic                fall;
    logic                frame_start;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [BIT_W-1:0]    bit_nxt;
    logic [BIT_W-1:0]    slot_pos;
    logic [BIT_W-1:0]    rel_pos;
    logic                right_nxt;
    logic                in_win;
    logic                dat_nxt;
    logic [SIDX_W-1:0]   sample_idx;
    logic [SAMPLE_W-1:0] load_left;
    logic [SAMPLE_W-1:0] load_right;
    logic [SAMPLE_W-1:0] cur_sample;

    assign in_bus.in_ready = !fifo_full && !reset;

    // Timing decode, FIFO status and the serial bit for the bit position entered on the next fall.
    always_comb begin
        tick        = (div_cnt == DIV_LAST);
        fall        = tick && AUD_BCLK;
        frame_start = fall && (bit_cnt == LAST_BIT);
        fifo_empty  = (wr_ptr == rd_ptr);
        fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        push        = in_bus.in_valid && in_bus.in_ready;
        pop         = frame_start && !fifo_empty;
        load_left   = fifo_empty ? '0 : fifo_left[rd_ptr[AW-1:0]];
        load_right  = fifo_empty ? '0 : fifo_right[rd_ptr[AW-1:0]];
        bit_nxt     = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
        right_nxt   = (bit_nxt >= SLOT_BITS);
        slot_pos    = right_nxt ? bit_nxt - SLOT_BITS : bit_nxt;
        // Positions before the offset wrap to a large value and fall outside the window.
        rel_pos     = slot_pos - OFFSET;
        in_win      = (rel_pos < SAMPLE_BITS);
        sample_idx  = SIDX_W'(SAMPLE_MSB - rel_pos);
        cur_sample  = right_nxt ? right_hold : (frame_start ? load_left : left_hold);
        dat_nxt     = in_win ? cur_sample[sample_idx] : 1'b0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt     <= '0;
            AUD_BCLK    <= 1'b0;
            bit_cnt     <= LAST_BIT;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
            underrun    <= 1'b0;
            left_hold   <= '0;
            right_hold  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            underrun <= 1'b0;
            div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                AUD_BCLK <= !AUD_BCLK;
            end
            if (fall) begin
                bit_cnt     <= bit_nxt;
                AUD_DACLRCK <= right_nxt;
                AUD_DACDAT  <= dat_nxt;
            end
            if (frame_start) begin
                left_hold  <= load_left;
                right_hold <= load_right;
                underrun   <= fifo_empty;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Frame storage; occupancy is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_left[wr_ptr[AW-1:0]]  <= in_bus.in_left;
            fifo_right[wr_ptr[AW-1:0]] <= in_bus.in_right;
        end
    end

`ifdef AUD_DAC_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            urun_cnt <= '0;
        end else if (frame_start && fifo_empty && (urun_cnt != 16'hFFFF)) begin
            urun_cnt <= urun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = urun_cnt;
`else
    assign underrun_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_aud_dac_serializer.sv
// Self-checking bench for aud_dac_serializer: I2S and left-justified instances against a frame-level reference model.
module tb_aud_dac_serializer;
    localparam int BD        = 8;
    localparam int SW        = 32;
    localparam int SMP       = 16;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 4 * SW * BD;
    localparam int FIRST_FS  = 2 * BD;

    typedef struct packed {
        logic [SMP-1:0] l;
        logic [SMP-1:0] r;
    } frame_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        bclk_a, lrck_a, dat_a, urun_a;
    logic        bclk_b, lrck_b, dat_b, urun_b;
    logic [15:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    aud_dac_serializer_if #(.SAMPLE_W(SMP)) if_i2s ();
    aud_dac_serializer_if #(.SAMPLE_W(SMP)) if_lj ();

    always #5 CLOCK_50 = ~CLOCK_50;

    aud_dac_serializer #(.SAMPLE_W(SMP), .SLOT_W(SW), .BCLK_DIV(BD), .FIFO_DEPTH(DEPTH), .I2S_MODE(1)) dut_i2s (
        .CLOCK_50(CLOCK_50), .reset(reset), .in_bus(if_i2s.slave),
        .AUD_BCLK(bclk_a), .AUD_DACLRCK(lrck_a), .AUD_DACDAT(dat_a),
        .underrun(urun_a), .underrun_cnt(cnt_a)
    );

    aud_dac_serializer #(.SAMPLE_W(SMP), .SLOT_W(SW), .BCLK_DIV(BD), .FIFO_DEPTH(DEPTH), .I2S_MODE(0)) dut_lj (
        .CLOCK_50(CLOCK_50), .reset(reset), .in_bus(if_lj.slave),
        .AUD_BCLK(bclk_b), .AUD_DACLRCK(lrck_b), .AUD_DACDAT(dat_b),
        .underrun(urun_b), .underrun_cnt(cnt_b)
    );

    // Reference model: cycle count since reset, queue of accepted frames, frame currently playing.
    int     c = 0;
    frame_t q[$];
    frame_t cur = '0;
    bit     exp_urun = 1'b0;
    int     urun_total = 0;

    always @(negedge CLOCK_50) begin : model
        bit was_full;
        was_full = (q.size() >= DEPTH);
        if (reset) begin
            c = 0;
            q.delete();
            cur = '0;
            exp_urun = 1'b0;
            urun_total = 0;
        end else begin
            c++;
            exp_urun = 1'b0;
            if (c >= FIRST_FS && ((c - FIRST_FS) % FRAME_CYC) == 0) begin
                if (q.size() == 0) begin
                    cur = '0;
                    exp_urun = 1'b1;
                    urun_total++;
                end else begin
                    cur = q.pop_front();
                end
            end
            if (if_i2s.in_valid && !was_full) q.push_back({if_i2s.in_left, if_i2s.in_right});
        end
    end

    function automatic logic f_bclk(int cc);
        return ((cc / BD) % 2) == 1;
    endfunction

    function automatic int f_bit(int cc);
        int k;
        k = cc / (2 * BD);
        if (k == 0) return -1;
        return (k - 1) % (2 * SW);
    endfunction

    function automatic logic f_lrck(int cc);
        return f_bit(cc) >= SW;
    endfunction

    function automatic logic f_dat(int cc, int o, frame_t f);
        int b;
        int p;
        logic [SMP-1:0] s;
        b = f_bit(cc);
        if (b < 0) return 1'b0;
        p = b % SW;
        s = (b >= SW) ? f.r : f.l;
        if (p >= o && p < o + SMP) return s[SMP-1-(p-o)];
        return 1'b0;
    endfunction

    function automatic logic [15:0] f_cnt();
`ifdef AUD_DAC_UNDERRUN_CNT_EN
        return (urun_total > 65535) ? 16'hFFFF : 16'(urun_total);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic f_ready();
        return !reset && (q.size() < DEPTH);
    endfunction

    task automatic step();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic drive(logic v, logic [SMP-1:0] l, logic [SMP-1:0] r);
        if_i2s.in_valid = v; if_i2s.in_left = l; if_i2s.in_right = r;
        if_lj.in_valid  = v; if_lj.in_left  = l; if_lj.in_right  = r;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        drive(1'b0, '0, '0);
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 16'h1111, 16'h2222);
        repeat (3) step();
        checks++; if (if_i2s.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", if_i2s.in_ready); end
        checks++; if ({bclk_a, lrck_a, dat_a, urun_a} !== 4'b0000) begin errors++; $display("FAIL reset_outs_i2s got %b exp 0000", {bclk_a, lrck_a, dat_a, urun_a}); end
        checks++; if ({bclk_b, lrck_b, dat_b, urun_b} !== 4'b0000) begin errors++; $display("FAIL reset_outs_lj got %b exp 0000", {bclk_b, lrck_b, dat_b, urun_b}); end
        checks++; if (cnt_a !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0000", cnt_a); end
        drive(1'b0, '0, '0);
        reset = 1'b0;
        step();
        checks++; if (if_i2s.in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", if_i2s.in_ready); end
    endtask

    task automatic test_single_frame();
        logic [15:0] l_s, r_s;
        logic [63:0] cap_a, cap_b, cap_lr, e_a, e_b, e_lr;
        int b;
        l_s = 16'hA5C3; r_s = 16'h1234;
        cap_a = '0; cap_b = '0; cap_lr = '0; e_a = '0; e_b = '0;
        e_lr = 64'hFFFFFFFF_00000000;
        for (int i = 0; i < 16; i++) begin
            e_a[1 + i]  = l_s[15 - i];
            e_a[33 + i] = r_s[15 - i];
            e_b[i]      = l_s[15 - i];
            e_b[32 + i] = r_s[15 - i];
        end
        do_reset(2);
        drive(1'b1, l_s, r_s);
        step();
        drive(1'b0, '0, '0);
        for (int n = 0; n < 2 * FRAME_CYC; n++) begin
            step();
            checks++; if (bclk_a !== f_bclk(c)) begin errors++; $display("FAIL bclk c=%0d got %b exp %b", c, bclk_a, f_bclk(c)); end
            checks++; if (lrck_a !== f_lrck(c)) begin errors++; $display("FAIL lrck c=%0d got %b exp %b", c, lrck_a, f_lrck(c)); end
            checks++; if (dat_a !== f_dat(c, 1, cur)) begin errors++; $display("FAIL dat_i2s c=%0d got %b exp %b", c, dat_a, f_dat(c, 1, cur)); end
            checks++; if (dat_b !== f_dat(c, 0, cur)) begin errors++; $display("FAIL dat_lj c=%0d got %b exp %b", c, dat_b, f_dat(c, 0, cur)); end
            if (c >= FIRST_FS && ((c - FIRST_FS) % (2 * BD)) == 0 && (c - FIRST_FS) / (2 * BD) < 64) begin
                b = (c - FIRST_FS) / (2 * BD);
                cap_a[b] = dat_a; cap_b[b] = dat_b; cap_lr[b] = lrck_a;
            end
        end
        checks++; if (cap_a !== e_a) begin errors++; $display("FAIL frame_i2s got %h exp %h", cap_a, e_a); end
        checks++; if (cap_b !== e_b) begin errors++; $display("FAIL frame_lj got %h exp %h", cap_b, e_b); end
        checks++; if (cap_lr !== e_lr) begin errors++; $display("FAIL frame_lrck got %h exp %h", cap_lr, e_lr); end
    endtask

    task automatic test_back_to_back();
        int  n_acc;
        bit  accept_now;
        n_acc = 0;
        do_reset(2);
        drive(1'b1, 16'($urandom), 16'($urandom));
        for (int n = 0; n < 7 * FRAME_CYC; n++) begin
            accept_now = if_i2s.in_valid && if_i2s.in_ready;
            step();
            if (accept_now) begin
                n_acc++;
                if (n_acc < 6) drive(1'b1, 16'($urandom), 16'($urandom));
                else drive(1'b0, '0, '0);
            end
            checks++; if (if_i2s.in_ready !== f_ready()) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp %b", c, if_i2s.in_ready, f_ready()); end
            checks++; if (if_lj.in_ready !== f_ready()) begin errors++; $display("FAIL b2b_ready_lj c=%0d got %b exp %b", c, if_lj.in_ready, f_ready()); end
            checks++; if (dat_a !== f_dat(c, 1, cur)) begin errors++; $display("FAIL b2b_dat c=%0d got %b exp %b", c, dat_a, f_dat(c, 1, cur)); end
            checks++; if (urun_a !== exp_urun) begin errors++; $display("FAIL b2b_urun c=%0d got %b exp %b", c, urun_a, exp_urun); end
        end
        checks++; if (n_acc != 6) begin errors++; $display("FAIL b2b_accepted got %0d exp 6", n_acc); end
    endtask

    task automatic test_random_traffic();
        do_reset(2);
        for (int n = 0; n < 4 * FRAME_CYC; n++) begin
            if ($urandom_range(0, 299) == 0) drive(1'b1, 16'($urandom), 16'($urandom));
            else drive(1'b0, '0, '0);
            step();
            checks++; if (if_i2s.in_ready !== f_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, if_i2s.in_ready, f_ready()); end
            checks++; if (dat_a !== f_dat(c, 1, cur)) begin errors++; $display("FAIL rnd_dat_i2s c=%0d got %b exp %b", c, dat_a, f_dat(c, 1, cur)); end
            checks++; if (dat_b !== f_dat(c, 0, cur)) begin errors++; $display("FAIL rnd_dat_lj c=%0d got %b exp %b", c, dat_b, f_dat(c, 0, cur)); end
            checks++; if (urun_b !== exp_urun) begin errors++; $display("FAIL rnd_urun c=%0d got %b exp %b", c, urun_b, exp_urun); end
        end
        drive(1'b0, '0, '0);
    endtask

    task automatic test_underrun();
        int pulses;
        int last_c;
        logic [15:0] e_cnt;
        pulses = 0; last_c = -1;
        do_reset(2);
        for (int n = 0; n < 3 * FRAME_CYC; n++) begin
            step();
            checks++; if (urun_a !== exp_urun) begin errors++; $display("FAIL urun c=%0d got %b exp %b", c, urun_a, exp_urun); end
            checks++; if (dat_a !== 1'b0) begin errors++; $display("FAIL urun_dat c=%0d got %b exp 0", c, dat_a); end
            checks++; if (cnt_a !== f_cnt()) begin errors++; $display("FAIL urun_cnt_track c=%0d got %0d exp %0d", c, cnt_a, f_cnt()); end
            if (urun_a === 1'b1) begin
                if (last_c >= 0) begin
                    checks++; if (c - last_c != FRAME_CYC) begin errors++; $display("FAIL urun_spacing got %0d exp %0d", c - last_c, FRAME_CYC); end
                end
                last_c = c;
                pulses++;
            end
        end
`ifdef AUD_DAC_UNDERRUN_CNT_EN
        e_cnt = 16'd3;
`else
        e_cnt = 16'd0;
`endif
        checks++; if (pulses != 3) begin errors++; $display("FAIL urun_pulses got %0d exp 3", pulses); end
        checks++; if (cnt_a !== e_cnt) begin errors++; $display("FAIL urun_cnt got %0d exp %0d", cnt_a, e_cnt); end
        checks++; if (cnt_b !== e_cnt) begin errors++; $display("FAIL urun_cnt_lj got %0d exp %0d", cnt_b, e_cnt); end
    endtask

    task automatic test_push_at_frame_start();
        logic [15:0] l_s, r_s;
        int guard;
        l_s = 16'($urandom) | 16'h8000;
        r_s = 16'($urandom);
        do_reset(2);
        guard = 0;
        while (c != FIRST_FS - 1 && guard < 100) begin
            step();
            guard++;
        end
        checks++; if (c != FIRST_FS - 1) begin errors++; $display("FAIL pfs_sync got c=%0d exp %0d", c, FIRST_FS - 1); end
        drive(1'b1, l_s, r_s);
        step();
        drive(1'b0, '0, '0);
        checks++; if (urun_a !== 1'b1) begin errors++; $display("FAIL pfs_urun got %b exp 1", urun_a); end
        for (int n = 0; n < 2 * FRAME_CYC; n++) begin
            step();
            checks++; if (dat_a !== f_dat(c, 1, cur)) begin errors++; $display("FAIL pfs_dat c=%0d got %b exp %b", c, dat_a, f_dat(c, 1, cur)); end
            checks++; if (urun_a !== exp_urun) begin errors++; $display("FAIL pfs_urun2 c=%0d got %b exp %b", c, urun_a, exp_urun); end
            if (c == FIRST_FS + FRAME_CYC + 2 * BD) begin
                checks++; if (dat_a !== l_s[15]) begin errors++; $display("FAIL pfs_msb got %b exp %b", dat_a, l_s[15]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        int ones;
        do_reset(2);
        drive(1'b1, 16'hFFFF, 16'hFFFF);
        repeat (3) step();
        drive(1'b0, '0, '0);
        guard = 0;
        while (c < 600 && guard < 1000) begin
            step();
            guard++;
        end
        checks++; if (q.size() != 2) begin errors++; $display("FAIL mid_queued got %0d exp 2", q.size()); end
        checks++; if (lrck_a !== 1'b1) begin errors++; $display("FAIL mid_right_slot got %b exp 1", lrck_a); end
        reset = 1'b1;
        step();
        checks++; if ({bclk_a, lrck_a, dat_a, urun_a, if_i2s.in_ready} !== 5'b00000) begin errors++; $display("FAIL mid_reset_outs got %b exp 00000", {bclk_a, lrck_a, dat_a, urun_a, if_i2s.in_ready}); end
        reset = 1'b0;
        step();
        checks++; if (if_i2s.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", if_i2s.in_ready); end
        ones = 0;
        for (int n = 0; n < 2 * FRAME_CYC; n++) begin
            step();
            if (dat_a === 1'b1 || dat_b === 1'b1) ones++;
            checks++; if (urun_a !== exp_urun) begin errors++; $display("FAIL mid_urun c=%0d got %b exp %b", c, urun_a, exp_urun); end
        end
        checks++; if (ones != 0) begin errors++; $display("FAIL mid_stale_data got %0d exp 0", ones); end
    endtask

    initial begin
        drive(1'b0, '0, '0);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_traffic();
        test_underrun();
        test_push_at_frame_start();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aud_dac_serializer.md
# aud_dac_serializer

Parametrised stereo audio DAC serializer for the Audio_Codec path. It accepts stereo PCM frames over a valid/ready handshake into a small FIFO, then generates AUD_BCLK and AUD_DACLRCK as codec-slave timing from CLOCK_50. It shifts samples out on AUD_DACDAT in I2S or left-justified format. Codec register setup over I2C and AUD_XCK generation are handled by other blocks.

## Interface
Parameters:
- SAMPLE_W, 16: PCM sample width per channel; legal range 8..SLOT_W-1.
- SLOT_W, 32: BCLK periods per channel slot, so 2*SLOT_W BCLK periods per frame.
- BCLK_DIV, 8: CLOCK_50 cycles per BCLK half-period; must be ≥2.
- FIFO_DEPTH, 4: stereo frames buffered; power of two, ≥2.
- I2S_MODE, 1: 1 selects I2S (MSB one BCLK after the LRCK edge); 0 selects left-justified (MSB on the LRCK edge).

Ports:
- CLOCK_50, in, 1: the only clock. All logic updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: a frame is offered on in_left/in_right.
- in_ready, out, 1: the FIFO can accept a frame.
- in_left, in, SAMPLE_W: left sample, two's complement.
- in_right, in, SAMPLE_W: right sample, two's complement.
- AUD_BCLK, out, 1: bit clock.
- AUD_DACLRCK, out, 1: 0 = left slot, 1 = right slot.
- AUD_DACDAT, out, 1: serial data.
- underrun, out, 1: one-cycle pulse when a frame start finds the FIFO empty.
- underrun_cnt, out, 16: saturating underrun count (see Configuration).

## Operation
- Reset (held ≥1 cycle):
  - div_cnt=0, AUD_BCLK=0, bit_cnt=2*SLOT_W-1, AUD_DACLRCK=0, AUD_DACDAT=0.
  - FIFO empty, underrun=0, underrun_cnt=0, shift registers cleared, in_ready=0.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - At wrap, AUD_BCLK toggles. A 0→1 toggle is a rise; a 1→0 toggle is a fall.
- On every fall, bit_cnt increments modulo 2*SLOT_W.
  - The cycle where bit_cnt wraps 2*SLOT_W-1 → 0 is the frame start.
- At frame start:
  - If the FIFO is non-empty, pop one frame into the left/right shift registers.
  - If it is empty, load zeros and pulse underrun for that cycle.
- On each fall, AUD_DACLRCK is set to (new bit_cnt ≥ SLOT_W).
- On each fall, AUD_DACDAT is set to the bit for the new bit_cnt. With slot position p = bit_cnt mod SLOT_W and offset o = I2S_MODE:
  - If o ≤ p < o+SAMPLE_W, drive sample bit [SAMPLE_W-1-(p-o)], MSB first.
  - Otherwise drive 0.
- Handshake:
  - in_ready = !full && !reset.
  - A push occurs when in_valid && in_ready at a rising edge.
  - No pass-through: a push into a full FIFO is refused even if a pop happens the same cycle.
- Push and pop in the same cycle with the FIFO empty: the pop sees empty (underrun, zeros) and the push is stored.
- Push and pop in the same cycle with the FIFO non-empty: both take effect and occupancy is unchanged.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished with an extra pointer bit.
- Reset mid-frame: everything returns to reset values on the next edge, and buffered frames are discarded. The partial frame is not completed.

## Timing
- BCLK period = 2*BCLK_DIV cycles. Frame = 4*SLOT_W*BCLK_DIV cycles. Defaults give 16 and 1024 cycles (≈48.83 kHz).
- The first fall comes 2*BCLK_DIV cycles after reset deasserts; it is the first frame start.
- All serial outputs change only in fall cycles and are stable for a full BCLK period, so the codec samples on the BCLK rise.
- Latency: a frame pushed into an empty FIFO at cycle t plays from the first frame start strictly after t.
- in_ready drops the cycle after the push that fills the FIFO. It rises the cycle after the pop that frees a slot.
- underrun is exactly one CLOCK_50 cycle wide and coincident with the frame-start fall.

## Configuration
- AUD_DAC_UNDERRUN_CNT_EN:
  - Defined: underrun_cnt increments on each underrun pulse and saturates at 16'hFFFF. It clears only on reset.
  - Undefined: the counter is not built and underrun_cnt is tied to 0. The underrun pulse still operates.

## Test plan
- Defaults, one push of L=16'hA5C3, R=16'h1234 after reset. Required response:
  - AUD_DACLRCK low for bits 0..31 and high for 32..63.
  - AUD_DACDAT=0 at bit 0; bits 1..16 read 1010010111000011; 0 for bits 17..32; bits 33..48 read 0001001000110100.
- I2S_MODE=0, same data → the MSB appears at bit 0 and bit 32; bits 16..31 and 48..63 are 0.
- Push 6 frames back-to-back with in_valid held high → in_ready=0 after 4 accepted. Frames then play in push order, each acceptance following a pop, with no loss or duplication.
- No pushes after reset → underrun pulses at each frame start, 1024 cycles apart. AUD_DACDAT stays 0. underrun_cnt reads 3 after three frames with the macro defined, and 0 without it.
- Push while empty exactly in the frame-start cycle → an underrun that frame, and the pushed frame plays in the next frame.
- Assert reset for 1 cycle in the middle of the right slot with 2 frames queued → all outputs return to reset values. in_ready=1 the cycle after reset deasserts, and no queued frame is ever transmitted.
